mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/reg_mem2wb.sv | 31 +++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: widths, writeback
// select encodings, FSM states and the writeback mux.
package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_NPC  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // WB_MEM only ever commits on a completed access, so rdata is valid there.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] npc,
    input logic [DATA_W-1:0] rdata
  );
    logic [DATA_W-1:0] res;
    res = '0;
    case (wb_sel_e'(sel))
      WB_ALU:  res = alu;
      WB_MEM:  res = rdata;
      WB_NPC:  res = npc;
      WB_ZERO: res = '0;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_mem2wb.sv
// MEM/WB pipeline register. A bubble cycle drops the write enable and holds
// the destination and data so downstream sees a stable no-op.
module reg_mem2wb
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              reg_write_in,
  input  logic [REG_W-1:0]  num_write_in,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic              reg_write_out,
  output logic [REG_W-1:0]  num_write_out,
  output logic [DATA_W-1:0] wb_data_out
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write_out <= 1'b0;
      num_write_out <= '0;
      wb_data_out   <= '0;
    end else if (bubble) begin
      reg_write_out <= 1'b0;
    end else begin
      reg_write_out <= reg_write_in;
      num_write_out <= num_write_in;
      wb_data_out   <= wb_data_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to a ready-handshaked data memory,
// stalls upstream while the access is outstanding and aborts on timeout.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_write_in,
  input  logic [1:0]        s_data_write_in,
  input  logic              reg_write_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] gpr_b_in,
  input  logic [REG_W-1:0]  num_write_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic              reg_write_out,
  output logic [REG_W-1:0]  num_write_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              err_out
);

  // Last ACCESS cycle index: the counter starts at zero on entry, so the
  // abort fires on the TIMEOUT_CYCLES-th cycle without ready.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mem_op;
  logic              stall;
  logic              bubble;
  logic              start;
  logic              finish;
  logic              abort;
  logic [DATA_W-1:0] wb_data;

  assign mem_op = mem_write_in | (s_data_write_in == WB_MEM);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    bubble    = 1'b1;
    start     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          start     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_ACCESS;
        end else begin
          bubble = 1'b0;
        end
      end
      ST_ACCESS: begin
        // Ready takes priority over a coincident timeout.
        if (dmem_ready) begin
          bubble    = 1'b0;
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign stall_out = stall & ~reset;
  assign wb_data   = wb_select(s_data_write_in, alu_res_in, npc_in, dmem_rdata);

  // FSM, wait counter and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      err_out <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (abort) begin
        err_out <= 1'b1;
      end
    end
  end

  // Memory request register: captured on ACCESS entry, held until done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write_in;
      dmem_addr  <= {alu_res_in[DATA_W-1:2], 2'b00};
      dmem_wdata <= gpr_b_in;
    end else if (finish || abort) begin
      dmem_req <= 1'b0;
    end
  end

  reg_mem2wb u_mem2wb (
    .clock         (clock),
    .reset         (reset),
    .bubble        (bubble),
    .reg_write_in  (reg_write_in),
    .num_write_in  (num_write_in),
    .wb_data_in    (wb_data),
    .reg_write_out (reg_write_out),
    .num_write_out (num_write_out),
    .wb_data_out   (wb_data_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU ops, loads, stores, timeout, reset abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_in;
  logic [1:0]  s_data_write_in;
  logic        reg_write_in;
  logic [31:0] npc_in, alu_res_in, gpr_b_in;
  logic [4:0]  num_write_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_out, reg_write_out;
  logic [4:0]  num_write_out;
  logic [31:0] wb_data_out;
  logic        err_out;

  int total = 0;
  int fails = 0;
  int stall_hi;

  mem_stage dut (
    .clock           (clk),
    .reset           (rst),
    .mem_write_in    (mem_write_in),
    .s_data_write_in (s_data_write_in),
    .reg_write_in    (reg_write_in),
    .npc_in          (npc_in),
    .alu_res_in      (alu_res_in),
    .gpr_b_in        (gpr_b_in),
    .num_write_in    (num_write_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .stall_out       (stall_out),
    .reg_write_out   (reg_write_out),
    .num_write_out   (num_write_out),
    .wb_data_out     (wb_data_out),
    .err_out         (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic [1:0] sel, input logic rw,
                       input logic [31:0] npc, input logic [31:0] alu,
                       input logic [31:0] gb, input logic [4:0] num);
    mem_write_in    = mw;
    s_data_write_in = sel;
    reg_write_in    = rw;
    npc_in          = npc;
    alu_res_in      = alu;
    gpr_b_in        = gb;
    num_write_in    = num;
  endtask

  initial begin
    rst = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_rw", reg_write_out, 0);
    check("rst_wb", wb_data_out, 0);
    check("rst_err", err_out, 0);
    check("rst_stall", stall_out, 0);
    rst = 1'b0;

    // ALU op, with a stray ready in IDLE that must be ignored
    drive(1'b0, 2'b00, 1'b1, 32'h4, 32'h0000_1234, 32'h0, 5'd5);
    dmem_ready = 1'b1;
    #1 check("alu_stall", stall_out, 0);
    tick();
    dmem_ready = 1'b0;
    check("alu_wb", wb_data_out, 32'h1234);
    check("alu_num", num_write_out, 5);
    check("alu_rw", reg_write_out, 1);
    check("alu_req", dmem_req, 0);

    // Select 11 writes zero
    drive(1'b0, 2'b11, 1'b1, 32'h8, 32'h0000_FFFF, 32'h0, 5'd6);
    tick();
    check("zero_wb", wb_data_out, 0);
    check("zero_num", num_write_out, 6);

    // Load: three waiting ACCESS cycles, ready on the fourth
    drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0103, 32'h0, 5'd7);
    stall_hi = 0;
    #1 if (stall_out) stall_hi++;
    check("ld_req_idle", dmem_req, 0);
    tick();
    check("ld_req", dmem_req, 1);
    check("ld_we", dmem_we, 0);
    check("ld_addr", dmem_addr, 32'h100);
    check("ld_bubble", reg_write_out, 0);
    for (int i = 0; i < 3; i++) begin
      if (stall_out) stall_hi++;
      tick();
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1 if (stall_out) stall_hi++;
    check("ld_stall_cnt", stall_hi, 4);
    check("ld_addr_held", dmem_addr, 32'h100);
    tick();
    dmem_ready = 1'b0;
    check("ld_wb", wb_data_out, 32'hDEAD_BEEF);
    check("ld_rw", reg_write_out, 1);
    check("ld_num", num_write_out, 7);
    check("ld_req_done", dmem_req, 0);
    // Back-to-back NPC writeback, no extra stall
    drive(1'b0, 2'b10, 1'b1, 32'h44, 32'h0, 32'h0, 5'd9);
    #1 check("b2b_stall", stall_out, 0);
    tick();
    check("b2b_wb", wb_data_out, 32'h44);
    check("b2b_num", num_write_out, 9);

    // Store: memory answers one cycle after seeing the request
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_0200, 32'hCAFE_0001, 5'd3);
    stall_hi = 0;
    #1 if (stall_out) stall_hi++;
    tick();
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'hCAFE_0001);
    check("st_addr", dmem_addr, 32'h200);
    if (stall_out) stall_hi++;
    tick();
    dmem_ready = 1'b1;
    #1 if (stall_out) stall_hi++;
    check("st_stall_cnt", stall_hi, 2);
    tick();
    dmem_ready = 1'b0;
    check("st_rw", reg_write_out, 0);
    check("st_req_done", dmem_req, 0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);

    // Ready coincides with the last allowed ACCESS cycle: ready wins
    tick();
    drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0400, 32'h0, 5'd10);
    tick();
    for (int i = 1; i < 255; i++) tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    #1 check("race_stall", stall_out, 0);
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    check("race_err", err_out, 0);
    check("race_wb", wb_data_out, 32'h1357_9BDF);
    check("race_rw", reg_write_out, 1);

    // Load that never completes: abort after 255 ACCESS cycles
    drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0300, 32'h0, 5'd4);
    stall_hi = 0;
    #1 if (stall_out) stall_hi++;
    tick();
    for (int i = 1; i < 255; i++) begin
      if (stall_out) stall_hi++;
      tick();
    end
    check("to_last_stall", stall_out, 0);
    check("to_stall_cnt", stall_hi, 255);
    check("to_err_before", err_out, 0);
    tick();
    check("to_err", err_out, 1);
    check("to_req", dmem_req, 0);
    check("to_rw", reg_write_out, 0);
    drive(1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0077, 32'h0, 5'd8);
    #1 check("to_stall_after", stall_out, 0);
    tick();
    check("to_err_sticky", err_out, 1);
    check("to_next_wb", wb_data_out, 32'h77);

    // Reset in the middle of a load access
    drive(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0500, 32'h0, 5'd11);
    tick();
    tick();
    check("rm_req_before", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rm_req", dmem_req, 0);
    check("rm_addr", dmem_addr, 0);
    check("rm_err", err_out, 0);
    check("rm_wb", wb_data_out, 0);
    check("rm_num", num_write_out, 0);
    check("rm_stall", stall_out, 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0055, 32'h0, 5'd2);
    #1 check("rm_alu_stall", stall_out, 0);
    tick();
    check("rm_alu_wb", wb_data_out, 32'h55);
    check("rm_alu_rw", reg_write_out, 1);
    check("rm_alu_num", num_write_out, 2);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
